// File: rtl/ball_collision_det_if.sv
// Bus between the ball position source and the brick-field collision detector.
// No valid/ready handshake: x_pos/y_pos are levels sampled every clock,
// new_level is a single-cycle pulse, and every output is a registered level
// (state_dbg mirrors the detector FSM state for observation).
interface ball_collision_det_if;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        new_level;
    logic [15:0] collision_det;
    logic [15:0] brick_alive;
    logic [11:0] score;
    logic        all_clear;
    logic        busy;
    logic [1:0]  state_dbg;

    modport master (
        output x_pos, y_pos, new_level,
        input  collision_det, brick_alive, score, all_clear, busy, state_dbg
    );

    modport slave (
        input  x_pos, y_pos, new_level,
        output collision_det, brick_alive, score, all_clear, busy, state_dbg
    );
endinterface

// File: rtl/ball_collision_det.sv
// Brick-field collision detector: keeps the 16-brick alive map, scans it one
// brick per cycle after each ball move, and publishes the hit vector, the
// remaining wall, a saturating score and a level-cleared flag.
module ball_collision_det #(
    parameter int BRICK_W   = 128,
    parameter int BRICK_H   = 32,
    parameter int BRICK_TOP = 64,
    parameter int BALL_R    = 10,
    parameter int BALL_X0   = 400,
    parameter int BALL_Y0   = 300
) (
    input logic pclk,
    input logic reset,
    ball_collision_det_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [11:0] lat_x, lat_y;
    logic [3:0]  idx;
    logic [15:0] acc;
    logic [4:0]  hit_cnt;
    logic [15:0] det_vec;
    logic [15:0] alive_map;
    logic [11:0] score_cnt;
    logic        clear_flag;

    logic        pos_changed;
    logic signed [12:0] brick_l, brick_r, brick_t, brick_b;
    logic signed [12:0] ball_l, ball_r, ball_t, ball_b;
    logic        overlap;
    logic [12:0] score_sum;
    logic [11:0] score_sat;

    assign pos_changed = ({bus.x_pos, bus.y_pos} != {lat_x, lat_y});

    // Geometry of brick idx and the latched ball box, then the inclusive overlap test.
    // The box is signed so a ball near the left/top edge does not wrap.
    always_comb begin
        brick_l = 13'(32'(idx[2:0]) * BRICK_W);
        brick_r = brick_l + 13'(BRICK_W - 1);
        brick_t = 13'(BRICK_TOP + 32'(idx[3]) * BRICK_H);
        brick_b = brick_t + 13'(BRICK_H - 1);
        ball_l  = $signed({1'b0, lat_x}) - $signed(13'(BALL_R));
        ball_r  = $signed({1'b0, lat_x}) + $signed(13'(BALL_R));
        ball_t  = $signed({1'b0, lat_y}) - $signed(13'(BALL_R));
        ball_b  = $signed({1'b0, lat_y}) + $signed(13'(BALL_R));
        overlap = (ball_l <= brick_r) && (ball_r >= brick_l) &&
                  (ball_t <= brick_b) && (ball_b >= brick_t);
    end

    // Score plus this scan's hits, clamped at 4095 instead of wrapping.
    always_comb begin
        score_sum = {1'b0, score_cnt} + {8'd0, hit_cnt};
        score_sat = score_sum[12] ? 12'hFFF : score_sum[11:0];
    end

    // State register.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a move starts a 16-cycle scan, then one DONE cycle; new_level aborts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pos_changed) state_nxt = SCAN;
            SCAN:    if (idx == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.new_level) state_nxt = IDLE;
    end

    // Datapath: latch on move, accumulate hits during SCAN, commit them in DONE.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            lat_x     <= 12'(BALL_X0);
            lat_y     <= 12'(BALL_Y0);
            idx       <= 4'd0;
            acc       <= 16'd0;
            hit_cnt   <= 5'd0;
            det_vec   <= 16'd0;
            alive_map <= 16'hFFFF;
            score_cnt <= 12'd0;
        end else if (bus.new_level) begin
            // Refill wins over everything, including a coinciding DONE.
            alive_map <= 16'hFFFF;
            det_vec   <= 16'd0;
            idx       <= 4'd0;
            acc       <= 16'd0;
            hit_cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pos_changed) begin
                        lat_x   <= bus.x_pos;
                        lat_y   <= bus.y_pos;
                        det_vec <= 16'd0;
                        acc     <= 16'd0;
                        hit_cnt <= 5'd0;
                        idx     <= 4'd0;
                    end
                end
                SCAN: begin
                    if (alive_map[idx] && overlap) begin
                        acc[idx] <= 1'b1;
                        hit_cnt  <= hit_cnt + 5'd1;
                    end
                    idx <= idx + 4'd1;
                end
                DONE: begin
                    det_vec   <= acc;
                    alive_map <= alive_map & ~acc;
                    score_cnt <= score_sat;
                end
                default: ;
            endcase
        end
    end

    // Level-cleared flag, one cycle behind the alive map.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) clear_flag <= 1'b0;
        else       clear_flag <= (alive_map == 16'd0);
    end

    assign bus.collision_det = det_vec;
    assign bus.brick_alive   = alive_map;
    assign bus.score         = score_cnt;
    assign bus.all_clear     = clear_flag;
    assign bus.busy          = (state != IDLE);
    assign bus.state_dbg     = state;

endmodule
